// File: rtl/stack_pkg.sv
// Shared definitions for the J1-style return/data stacks: delta encodings and
// modulo-N pointer stepping without a divider.
package stack_pkg;

  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_ILL  = 2'b10;
  localparam logic [1:0] DELTA_POP  = 2'b11;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

endpackage

// File: rtl/param_return_stack_if.sv
// Control and status bundle between the execute stage (master) and a stack (slave).
interface param_return_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             clr;
  logic [1:0]       delta;
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             ill;

  modport master (
    output clr, delta, wen, din, err_clr,
    input  tos, nos, depth, empty, full, ovf, unf, ill
  );

  modport slave (
    input  clr, delta, wen, din, err_clr,
    output tos, nos, depth, empty, full, ovf, unf, ill
  );
endinterface

// File: rtl/stack_ram.sv
// Spill storage below TOS: synchronous write, asynchronous read, no reset.
module stack_ram #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ENTRIES = 31,
  parameter int unsigned AW      = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_return_stack.sv
// LIFO with registered TOS and a RAM of DEPTH-1 spilled entries; owns its pointer,
// supports push/pop/replace, saturate or wrap on overflow, sticky error flags.
module param_return_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WRAP  = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  param_return_stack_if.slave bus
);

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned RAM_N = DEPTH - 1;
  localparam int unsigned PW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  logic             ram_we;
  logic [PW-1:0]    rd_addr;
  logic [WIDTH-1:0] ram_rdata;
  logic             full, empty, two_plus;

  assign full     = (depth_q == CW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign two_plus = (depth_q >= CW'(2));
  assign rd_addr  = PW'(wrap_dec(32'(wp_q), RAM_N));

  stack_ram #(
    .WIDTH  (WIDTH),
    .ENTRIES(RAM_N),
    .AW     (PW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(wp_q),
    .wdata_i(tos_q),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    tos_d   = tos_q;
    depth_d = depth_q;
    wp_d    = wp_q;
    ram_we  = 1'b0;
    ovf_d   = ovf_q & ~bus.err_clr;
    unf_d   = unf_q & ~bus.err_clr;
    ill_d   = ill_q & ~bus.err_clr;
    if (bus.clr) begin
      tos_d   = '0;
      depth_d = '0;
      wp_d    = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      ill_d   = 1'b0;
    end else begin
      unique case (bus.delta)
        DELTA_PUSH: begin
          if (full) ovf_d = 1'b1;
          // Saturating mode drops the whole op, including the TOS load.
          if (!full || WRAP != 0) begin
            if (!empty) begin
              ram_we = 1'b1;
              wp_d   = PW'(wrap_inc(32'(wp_q), RAM_N));
            end
            if (bus.wen) tos_d = bus.din;
            if (!full) depth_d = depth_q + CW'(1);
          end
        end
        DELTA_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            if (bus.wen)       tos_d = bus.din;
            else if (two_plus) tos_d = ram_rdata;
            else               tos_d = '0;
            if (two_plus) wp_d = rd_addr;
            depth_d = depth_q - CW'(1);
          end
        end
        DELTA_ILL: begin
          ill_d = 1'b1;
          if (bus.wen) tos_d = bus.din;
        end
        default: begin
          if (bus.wen) tos_d = bus.din;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tos_q   <= '0;
      depth_q <= '0;
      wp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      depth_q <= depth_d;
      wp_q    <= wp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.tos   = tos_q;
  assign bus.nos   = two_plus ? ram_rdata : '0;
  assign bus.depth = depth_q;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.ill   = ill_q;

endmodule

// File: tb/tb_param_return_stack.sv
// Directed test of three stack instances (32 deep saturate, 4 deep saturate, 4 deep wrap)
// driven by shared stimulus with hand-computed expectations.
module tb_param_return_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, wen, err_clr;
  logic [1:0]  delta;
  logic [15:0] din;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  param_return_stack_if #(.WIDTH(16), .DEPTH(32)) bus_l ();
  param_return_stack_if #(.WIDTH(16), .DEPTH(4))  bus_s ();
  param_return_stack_if #(.WIDTH(16), .DEPTH(4))  bus_w ();

  assign bus_l.clr = clr;  assign bus_l.delta = delta;  assign bus_l.wen = wen;
  assign bus_l.din = din;  assign bus_l.err_clr = err_clr;
  assign bus_s.clr = clr;  assign bus_s.delta = delta;  assign bus_s.wen = wen;
  assign bus_s.din = din;  assign bus_s.err_clr = err_clr;
  assign bus_w.clr = clr;  assign bus_w.delta = delta;  assign bus_w.wen = wen;
  assign bus_w.din = din;  assign bus_w.err_clr = err_clr;

  param_return_stack #(.WIDTH(16), .DEPTH(32), .WRAP(0)) u_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l));
  param_return_stack #(.WIDTH(16), .DEPTH(4), .WRAP(0)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  param_return_stack #(.WIDTH(16), .DEPTH(4), .WRAP(1)) u_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one op across a clock edge, then sample 1 time unit later.
  task automatic op(input logic [1:0] d, input logic w, input logic [15:0] v,
                    input logic ec = 1'b0, input logic c = 1'b0);
    delta = d; wen = w; din = v; err_clr = ec; clr = c;
    @(posedge clk);
    #1;
    delta = 2'b00; wen = 1'b0; din = '0; err_clr = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; delta = 2'b00; wen = 1'b0; din = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check_eq("rst_tos",   32'(bus_l.tos),   0);
    check_eq("rst_depth", 32'(bus_l.depth), 0);
    check_eq("rst_empty", 32'(bus_l.empty), 1);
    check_eq("rst_full",  32'(bus_l.full),  0);
    check_eq("rst_flags", {29'd0, bus_l.ovf, bus_l.unf, bus_l.ill}, 0);

    op(2'b01, 1'b1, 16'h1111);
    op(2'b01, 1'b1, 16'h2222);
    op(2'b01, 1'b1, 16'h3333);
    check_eq("push3_tos",   32'(bus_l.tos),   32'h3333);
    check_eq("push3_nos",   32'(bus_l.nos),   32'h2222);
    check_eq("push3_depth", 32'(bus_l.depth), 3);
    check_eq("push3_empty", 32'(bus_l.empty), 0);

    op(2'b11, 1'b0, 16'h0);
    check_eq("pop1_tos", 32'(bus_l.tos), 32'h2222);
    check_eq("pop1_nos", 32'(bus_l.nos), 32'h1111);
    op(2'b11, 1'b0, 16'h0);
    check_eq("pop2_tos",   32'(bus_l.tos),   32'h1111);
    check_eq("pop2_depth", 32'(bus_l.depth), 1);
    check_eq("pop2_nos",   32'(bus_l.nos),   0);
    op(2'b11, 1'b0, 16'h0);
    check_eq("pop3_tos",   32'(bus_l.tos),   0);
    check_eq("pop3_depth", 32'(bus_l.depth), 0);
    check_eq("pop3_empty", 32'(bus_l.empty), 1);

    op(2'b11, 1'b1, 16'hBEEF);
    check_eq("unf_tos",   32'(bus_l.tos),   0);
    check_eq("unf_depth", 32'(bus_l.depth), 0);
    check_eq("unf_flag",  32'(bus_l.unf),   1);
    op(2'b11, 1'b1, 16'hBEEF, 1'b1);
    check_eq("unf_setwins", 32'(bus_l.unf), 1);
    op(2'b00, 1'b0, 16'h0, 1'b1);
    check_eq("unf_cleared", 32'(bus_l.unf), 0);

    op(2'b01, 1'b1, 16'h000A);
    op(2'b01, 1'b1, 16'h000B);
    op(2'b10, 1'b1, 16'hAAAA);
    check_eq("ill_tos",   32'(bus_l.tos),   32'hAAAA);
    check_eq("ill_nos",   32'(bus_l.nos),   32'h000A);
    check_eq("ill_depth", 32'(bus_l.depth), 2);
    check_eq("ill_flag",  32'(bus_l.ill),   1);
    op(2'b00, 1'b1, 16'h5555);
    check_eq("hold_wen_tos", 32'(bus_l.tos),   32'h5555);
    check_eq("hold_depth",   32'(bus_l.depth), 2);
    op(2'b01, 1'b1, 16'h7777, 1'b0, 1'b1);
    check_eq("clr_depth", 32'(bus_l.depth), 0);
    check_eq("clr_tos",   32'(bus_l.tos),   0);
    check_eq("clr_flags", {29'd0, bus_l.ovf, bus_l.unf, bus_l.ill}, 0);

    for (int i = 1; i <= 5; i++) op(2'b01, 1'b1, 16'(i));
    check_eq("sat_depth", 32'(bus_s.depth), 4);
    check_eq("sat_tos",   32'(bus_s.tos),   4);
    check_eq("sat_nos",   32'(bus_s.nos),   3);
    check_eq("sat_ovf",   32'(bus_s.ovf),   1);
    check_eq("sat_full",  32'(bus_s.full),  1);
    check_eq("big_noovf", 32'(bus_l.ovf),   0);
    op(2'b00, 1'b0, 16'h0, 1'b1);
    check_eq("sat_ovf_clr", 32'(bus_s.ovf), 0);

    op(2'b00, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) op(2'b01, 1'b1, 16'(i));
    check_eq("wrap_depth", 32'(bus_w.depth), 4);
    check_eq("wrap_tos",   32'(bus_w.tos),   6);
    check_eq("wrap_nos",   32'(bus_w.nos),   5);
    check_eq("wrap_ovf",   32'(bus_w.ovf),   1);
    op(2'b11, 1'b0, 16'h0);
    check_eq("wrap_pop1", 32'(bus_w.tos), 5);
    op(2'b11, 1'b0, 16'h0);
    check_eq("wrap_pop2", 32'(bus_w.tos), 4);
    op(2'b11, 1'b0, 16'h0);
    check_eq("wrap_pop3",   32'(bus_w.tos),   3);
    check_eq("wrap_depth1", 32'(bus_w.depth), 1);
    op(2'b11, 1'b0, 16'h0);
    check_eq("wrap_depth0", 32'(bus_w.depth), 0);
    check_eq("wrap_tos0",   32'(bus_w.tos),   0);
    check_eq("wrap_ovf_st", 32'(bus_w.ovf),   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_return_stack.md
Name: param_return_stack

Overview:
Parametrised successor to the CPU's return stack. It is a LIFO that owns its own pointer, so the core no longer computes rsp_next. The top of stack (TOS) is held in a register. Entries below TOS sit in an internal array with combinational read, so TOS and NOS are both valid in the same cycle. It sits beside the J1-style execute stage and serves both the return stack and the data stack, one instance each. It adds J1 push/pop/replace ops, saturate or wrap overflow policy, sticky error flags and a soft clear.

Parameters:
WIDTH, 16, entry width in bits.
DEPTH, 32, total capacity including TOS. Minimum 2, any integer.
WRAP, 0, overflow policy. 0 = saturate (push when full is rejected). 1 = circular (push when full overwrites the oldest entry).
CW, $clog2(DEPTH+1), width of the depth counter (localparam).

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
clr  in  1  soft clear. Empties the stack and clears the error flags. Does not touch array contents.
delta  in  2  pointer move. 2'b01 = +1 (push), 2'b11 = -1 (pop), 2'b00 = hold, 2'b10 = illegal.
wen  in  1  load din into TOS this cycle.
din  in  WIDTH  new TOS value.
err_clr  in  1  clears ovf, unf and ill.
tos  out  WIDTH  top of stack (registered).
nos  out  WIDTH  next on stack. Combinational array read; 0 when depth<2.
depth  out  CW  number of valid entries, 0..DEPTH.
empty  out  1  depth==0
full  out  1  depth==DEPTH
ovf  out  1  sticky overflow flag
unf  out  1  sticky underflow flag
ill  out  1  sticky illegal-delta flag

Behaviour:
- Reset (rst_n=0 at a clk edge): tos=0, depth=0, ovf=unf=ill=0, internal pointers=0. Array contents are not reset.
- clr=1 has the same effect as reset, except the array is untouched. clr has priority over any op in that cycle.
- err_clr=1 clears the flags. If an error occurs in the same cycle, the set wins.
- All ops are single-cycle. Results are visible on tos/nos/depth on the cycle after the edge.
- Storage: RAM of DEPTH-1 entries plus a pointer wp = slot where the next spilled TOS is written. NOS = ram[wp-1], with mod DEPTH-1 arithmetic done by explicit compare-and-wrap (no power-of-two requirement).
- Push (01):
  - If depth>0, ram[wp] <= tos and wp advances.
  - tos <= wen ? din : tos (no wen means DUP).
  - depth increments.
- Pop (11):
  - tos <= wen ? din : (depth>=2 ? nos : 0).
  - wp retreats if depth>=2.
  - depth decrements.
- Hold (00): if wen, tos <= din. Nothing else changes.
- Illegal (10): treated as hold (wen still honoured) and sets ill.
- Push when full:
  - WRAP=0: the whole op is dropped, including wen, and ovf is set.
  - WRAP=1: the oldest entry is overwritten (ram[wp] <= tos, wp advances), depth stays DEPTH, tos is updated, and ovf is set.
- Pop when empty: the op is dropped, including wen, and unf is set.
- Pop when depth==1: tos <= wen ? din : 0, and depth becomes 0.
- empty and full are combinational from depth. They are never both 1 because DEPTH>=2.

Decomposition:
- Shared package `stack_pkg`:
  - delta encodings DELTA_HOLD/PUSH/POP/ILL.
  - function `wrap_inc`/`wrap_dec` (modulo-N step without a divider).
- One sub-module: `stack_ram`. WIDTH x (DEPTH-1) array, synchronous write, asynchronous read, no reset on the array. It is reused by the data-stack instance.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 (delta=01, wen=1) → tos=0x3333, nos=0x2222, depth=3, empty=0.
- Pop with wen=0 ×2 from that state → tos=0x2222 then 0x1111; depth=1; nos=0; a third pop gives tos=0, depth=0, empty=1.
- DEPTH=4, WRAP=0: push 1..5 → after the 5th push depth=4, tos=4, nos=3, ovf=1. Then err_clr → ovf=0.
- DEPTH=4, WRAP=1: push 1..6 → depth=4, tos=6, nos=5. Pops yield 5, 4, 3, then depth hits 0 with ovf=1.
- Empty, pop with wen=1, din=0xBEEF → tos=0, depth=0, unf=1. Same cycle with err_clr=1 → unf=1 (set wins).
- depth=2, delta=10, wen=1, din=0xAAAA → tos=0xAAAA, depth=2, ill=1. Then clr mid-sequence → depth=0, tos=0, flags=0.
